// File: rtl/hms_time_keeper_pkg.sv
// Shared definitions for the hours/minutes/seconds time keeper: FSM encoding,
// field-select codes, field terminal values and the packed-BCD validity check.
package hms_time_keeper_pkg;

  typedef logic [7:0] bcd_t;

  localparam logic [0:0] STATE_STOP = 1'b0;
  localparam logic [0:0] STATE_RUN  = 1'b1;

  localparam logic [1:0] SEL_SEC  = 2'b00;
  localparam logic [1:0] SEL_MIN  = 2'b01;
  localparam logic [1:0] SEL_HOUR = 2'b10;
  localparam logic [1:0] SEL_RSVD = 2'b11;

  localparam bcd_t SEC_MAX = 8'h59;
  localparam bcd_t MIN_MAX = 8'h59;

  // True when both nibbles hold a decimal digit.
  function automatic logic bcd_valid(input bcd_t v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter that wraps to 00 after {MOD_TENS,MOD_UNITS}.
// wrap is combinational so the next field can step on the same edge.
module bcd_mod_counter
  import hms_time_keeper_pkg::*;
#(
  parameter logic [3:0] MOD_TENS  = 4'd5,
  parameter logic [3:0] MOD_UNITS = 4'd9
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic load,
  input  bcd_t load_val,
  output bcd_t value,
  output logic wrap
);

  logic at_max;

  assign at_max = (value[7:4] == MOD_TENS) && (value[3:0] == MOD_UNITS);
  assign wrap   = inc && at_max;

  // Load outranks increment; arithmetic stays per nibble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= 8'h00;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      if (at_max) begin
        value <= 8'h00;
      end else if (value[3:0] == 4'd9) begin
        value <= {value[7:4] + 4'd1, 4'd0};
      end else begin
        value <= {value[7:4], value[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/hms_time_keeper.sv
// Time-of-day keeper in packed BCD: STOP/RUN FSM, field-load validation,
// seconds->minutes->hours carry chain and the day_carry/set_err pulses.
module hms_time_keeper
  import hms_time_keeper_pkg::*;
#(
  parameter int HOUR_MOD = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       run,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic [7:0] set_val,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       day_carry,
  output logic       set_err,
  output logic       running
);

  localparam logic [3:0] HOUR_TENS  = (HOUR_MOD == 12) ? 4'd1 : 4'd2;
  localparam logic [3:0] HOUR_UNITS = (HOUR_MOD == 12) ? 4'd1 : 4'd3;
  localparam bcd_t       HOUR_MAX   = {HOUR_TENS, HOUR_UNITS};

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic       load_ok;
  logic       tick_eff;
  logic       sec_wrap;
  logic       min_wrap;
  logic       hour_wrap;
  logic       load_sec;
  logic       load_min;
  logic       load_hour;

  always_comb begin
    state_nxt = state;
    case (state)
      STATE_STOP: if (run && !set_en) state_nxt = STATE_RUN;
      STATE_RUN:  if (!run || set_en) state_nxt = STATE_STOP;
      default:    state_nxt = STATE_STOP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= STATE_STOP;
    else     state <= state_nxt;
  end

  assign running = (state == STATE_RUN);

  // Packed BCD orders like the decimal value once both nibbles are digits.
  always_comb begin
    load_ok = 1'b0;
    if (bcd_valid(set_val)) begin
      case (set_sel)
        SEL_SEC:  load_ok = (set_val <= SEC_MAX);
        SEL_MIN:  load_ok = (set_val <= MIN_MAX);
        SEL_HOUR: load_ok = (set_val <= HOUR_MAX);
        default:  load_ok = 1'b0;
      endcase
    end
  end

  assign load_sec  = set_en && load_ok && (set_sel == SEL_SEC);
  assign load_min  = set_en && load_ok && (set_sel == SEL_MIN);
  assign load_hour = set_en && load_ok && (set_sel == SEL_HOUR);

  // Any strobe, valid or not, swallows a coincident tick.
  assign tick_eff = running && tick_in && !set_en;

  bcd_mod_counter #(.MOD_TENS(SEC_MAX[7:4]), .MOD_UNITS(SEC_MAX[3:0])) u_sec (
    .clk      (clk),
    .rst      (rst),
    .inc      (tick_eff),
    .load     (load_sec),
    .load_val (set_val),
    .value    (sec_bcd),
    .wrap     (sec_wrap)
  );

  bcd_mod_counter #(.MOD_TENS(MIN_MAX[7:4]), .MOD_UNITS(MIN_MAX[3:0])) u_min (
    .clk      (clk),
    .rst      (rst),
    .inc      (sec_wrap),
    .load     (load_min),
    .load_val (set_val),
    .value    (min_bcd),
    .wrap     (min_wrap)
  );

  bcd_mod_counter #(.MOD_TENS(HOUR_TENS), .MOD_UNITS(HOUR_UNITS)) u_hour (
    .clk      (clk),
    .rst      (rst),
    .inc      (min_wrap),
    .load     (load_hour),
    .load_val (set_val),
    .value    (hour_bcd),
    .wrap     (hour_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      day_carry <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      day_carry <= hour_wrap;
      set_err   <= set_en && !load_ok;
    end
  end

endmodule

// File: tb/tb_hms_time_keeper.sv
// Directed bench for hms_time_keeper: a 24-hour and a 12-hour instance share
// stimulus; each scenario task checks hand-computed values inline.
module tb_hms_time_keeper;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_in = 1'b0;
  logic       run = 1'b0;
  logic       set_en = 1'b0;
  logic [1:0] set_sel = 2'b00;
  logic [7:0] set_val = 8'h00;

  logic [7:0] sec24, min24, hour24, sec12, min12, hour12;
  logic       day24, err24, run24, day12, err12, run12;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hms_time_keeper #(.HOUR_MOD(24)) dut24 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .run(run), .set_en(set_en),
    .set_sel(set_sel), .set_val(set_val), .sec_bcd(sec24), .min_bcd(min24),
    .hour_bcd(hour24), .day_carry(day24), .set_err(err24), .running(run24)
  );

  hms_time_keeper #(.HOUR_MOD(12)) dut12 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .run(run), .set_en(set_en),
    .set_sel(set_sel), .set_val(set_val), .sec_bcd(sec12), .min_bcd(min12),
    .hour_bcd(hour12), .day_carry(day12), .set_err(err12), .running(run12)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Returns 1 time unit after the rising edge, outputs settled.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [1:0] sel, input logic [7:0] val);
    set_en  = 1'b1;
    set_sel = sel;
    set_val = val;
    cycle();
    set_en  = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    vectors++; if (sec24 !== 8'h00) begin miscompares++; $display("FAIL reset_sec: got %h want 00", sec24); end
    vectors++; if (min24 !== 8'h00) begin miscompares++; $display("FAIL reset_min: got %h want 00", min24); end
    vectors++; if (hour24 !== 8'h00) begin miscompares++; $display("FAIL reset_hour: got %h want 00", hour24); end
    vectors++; if ({day24, err24, run24} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {day24, err24, run24}); end
    run = 1'b1;
    tick_in = 1'b1;
    cycle();
    cycle();
    vectors++; if ({sec24, run24, sec12, run12} !== 18'h0) begin miscompares++; $display("FAIL reset_held: got sec24=%h run24=%b sec12=%h run12=%b want zeros", sec24, run24, sec12, run12); end
    tick_in = 1'b0;
    run = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_sixty_ticks();
    logic day_seen;
    day_seen = 1'b0;
    run = 1'b1;
    cycle();
    vectors++; if (run24 !== 1'b1) begin miscompares++; $display("FAIL sixty_running: got %b want 1", run24); end
    vectors++; if (sec24 !== 8'h00) begin miscompares++; $display("FAIL sixty_start_sec: got %h want 00", sec24); end
    tick_in = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      cycle();
      if (day24 !== 1'b0) day_seen = 1'b1;
      if (i == 1) begin
        vectors++; if (sec24 !== 8'h01) begin miscompares++; $display("FAIL sixty_first_tick: got %h want 01", sec24); end
      end
      if (i == 10) begin
        vectors++; if (sec24 !== 8'h10) begin miscompares++; $display("FAIL sixty_units_roll: got %h want 10", sec24); end
      end
    end
    tick_in = 1'b0;
    vectors++; if (sec24 !== 8'h00) begin miscompares++; $display("FAIL sixty_sec: got %h want 00", sec24); end
    vectors++; if (min24 !== 8'h01) begin miscompares++; $display("FAIL sixty_min: got %h want 01", min24); end
    vectors++; if (min12 !== 8'h01) begin miscompares++; $display("FAIL sixty_min12: got %h want 01", min12); end
    vectors++; if (day_seen !== 1'b0) begin miscompares++; $display("FAIL sixty_day_carry: got %b want 0", day_seen); end
    run = 1'b0;
    cycle();
    vectors++; if (run24 !== 1'b0) begin miscompares++; $display("FAIL sixty_stop: got %b want 0", run24); end
  endtask

  task automatic test_day_wrap();
    do_load(2'b00, 8'h59);
    vectors++; if (sec24 !== 8'h59) begin miscompares++; $display("FAIL wrap_load_sec: got %h want 59", sec24); end
    vectors++; if (min24 !== 8'h01) begin miscompares++; $display("FAIL wrap_load59_no_carry: got %h want 01", min24); end
    vectors++; if (err24 !== 1'b0) begin miscompares++; $display("FAIL wrap_load_err: got %b want 0", err24); end
    do_load(2'b01, 8'h59);
    vectors++; if (min24 !== 8'h59) begin miscompares++; $display("FAIL wrap_load_min: got %h want 59", min24); end
    do_load(2'b10, 8'h23);
    vectors++; if (hour24 !== 8'h23) begin miscompares++; $display("FAIL wrap_load_hour: got %h want 23", hour24); end
    run = 1'b1;
    cycle();
    tick_in = 1'b1;
    cycle();
    tick_in = 1'b0;
    vectors++; if ({hour24, min24, sec24} !== 24'h000000) begin miscompares++; $display("FAIL wrap_time: got %h:%h:%h want 00:00:00", hour24, min24, sec24); end
    vectors++; if (day24 !== 1'b1) begin miscompares++; $display("FAIL wrap_day_carry: got %b want 1", day24); end
    cycle();
    vectors++; if (day24 !== 1'b0) begin miscompares++; $display("FAIL wrap_day_pulse_width: got %b want 0", day24); end
    run = 1'b0;
    cycle();
  endtask

  task automatic test_hour12();
    do_load(2'b10, 8'h11);
    vectors++; if (hour12 !== 8'h11) begin miscompares++; $display("FAIL h12_load11: got %h want 11", hour12); end
    vectors++; if (err12 !== 1'b0) begin miscompares++; $display("FAIL h12_load11_err: got %b want 0", err12); end
    do_load(2'b10, 8'h12);
    vectors++; if (err12 !== 1'b1) begin miscompares++; $display("FAIL h12_load12_err: got %b want 1", err12); end
    vectors++; if (hour12 !== 8'h11) begin miscompares++; $display("FAIL h12_load12_hold: got %h want 11", hour12); end
    vectors++; if ({hour24, err24} !== {8'h12, 1'b0}) begin miscompares++; $display("FAIL h24_load12: got hour=%h err=%b want 12/0", hour24, err24); end
    cycle();
    vectors++; if (err12 !== 1'b0) begin miscompares++; $display("FAIL h12_err_pulse_width: got %b want 0", err12); end
    do_load(2'b01, 8'h59);
    do_load(2'b00, 8'h59);
    run = 1'b1;
    cycle();
    tick_in = 1'b1;
    cycle();
    tick_in = 1'b0;
    vectors++; if ({hour12, min12, sec12, day12} !== {24'h000000, 1'b1}) begin miscompares++; $display("FAIL h12_wrap: got %h:%h:%h day=%b want 00:00:00 day=1", hour12, min12, sec12, day12); end
    vectors++; if ({hour24, min24, sec24, day24} !== {24'h130000, 1'b0}) begin miscompares++; $display("FAIL h24_hour_step: got %h:%h:%h day=%b want 13:00:00 day=0", hour24, min24, sec24, day24); end
    run = 1'b0;
    cycle();
  endtask

  task automatic test_bad_loads();
    do_load(2'b01, 8'h34);
    vectors++; if (min24 !== 8'h34) begin miscompares++; $display("FAIL bad_setup_min: got %h want 34", min24); end
    do_load(2'b01, 8'h5A);
    vectors++; if ({err24, min24} !== {1'b1, 8'h34}) begin miscompares++; $display("FAIL bad_nibble: got err=%b min=%h want 1/34", err24, min24); end
    do_load(2'b01, 8'h60);
    vectors++; if ({err24, min24} !== {1'b1, 8'h34}) begin miscompares++; $display("FAIL bad_range: got err=%b min=%h want 1/34", err24, min24); end
    do_load(2'b11, 8'h00);
    vectors++; if (err24 !== 1'b1) begin miscompares++; $display("FAIL bad_sel_err: got %b want 1", err24); end
    vectors++; if ({hour24, min24, sec24} !== 24'h133400) begin miscompares++; $display("FAIL bad_sel_hold: got %h:%h:%h want 13:34:00", hour24, min24, sec24); end
    cycle();
    vectors++; if (err24 !== 1'b0) begin miscompares++; $display("FAIL bad_err_clear: got %b want 0", err24); end
  endtask

  task automatic test_collision();
    do_load(2'b00, 8'h59);
    run = 1'b1;
    cycle();
    vectors++; if (run24 !== 1'b1) begin miscompares++; $display("FAIL coll_running: got %b want 1", run24); end
    set_en = 1'b1;
    set_sel = 2'b00;
    set_val = 8'h07;
    tick_in = 1'b1;
    cycle();
    set_en = 1'b0;
    vectors++; if ({sec24, min24} !== 16'h0734) begin miscompares++; $display("FAIL coll_load_wins: got sec=%h min=%h want 07/34", sec24, min24); end
    vectors++; if ({run24, err24} !== 2'b00) begin miscompares++; $display("FAIL coll_stop: got running=%b err=%b want 0/0", run24, err24); end
    cycle();
    vectors++; if ({sec24, run24} !== {8'h07, 1'b1}) begin miscompares++; $display("FAIL coll_tick_in_stop: got sec=%h running=%b want 07/1", sec24, run24); end
    cycle();
    vectors++; if (sec24 !== 8'h08) begin miscompares++; $display("FAIL coll_resume: got %h want 08", sec24); end
    tick_in = 1'b0;
    run = 1'b0;
    cycle();
  endtask

  task automatic test_reset_mid_run();
    do_load(2'b10, 8'h12);
    do_load(2'b01, 8'h34);
    do_load(2'b00, 8'h56);
    run = 1'b1;
    cycle();
    vectors++; if ({hour24, min24, sec24, run24} !== {24'h123456, 1'b1}) begin miscompares++; $display("FAIL mid_setup: got %h:%h:%h running=%b want 12:34:56/1", hour24, min24, sec24, run24); end
    #2;
    rst = 1'b1;
    tick_in = 1'b1;
    run = 1'b0;
    #1;
    vectors++; if ({hour24, min24, sec24} !== 24'h000000) begin miscompares++; $display("FAIL mid_async_time: got %h:%h:%h want 00:00:00", hour24, min24, sec24); end
    vectors++; if ({day24, err24, run24} !== 3'b000) begin miscompares++; $display("FAIL mid_async_flags: got %b want 000", {day24, err24, run24}); end
    #1 rst = 1'b0;
    cycle();
    vectors++; if ({sec24, run24} !== {8'h00, 1'b0}) begin miscompares++; $display("FAIL mid_tick_ignored: got sec=%h running=%b want 00/0", sec24, run24); end
    run = 1'b1;
    cycle();
    vectors++; if ({sec24, run24} !== {8'h00, 1'b1}) begin miscompares++; $display("FAIL mid_rerun: got sec=%h running=%b want 00/1", sec24, run24); end
    cycle();
    vectors++; if (sec24 !== 8'h01) begin miscompares++; $display("FAIL mid_count: got %h want 01", sec24); end
    tick_in = 1'b0;
    run = 1'b0;
    cycle();
  endtask

  initial begin
    test_reset();
    test_sixty_ticks();
    test_day_wrap();
    test_hour12();
    test_bad_loads();
    test_collision();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
